// File: rtl/mul_if.sv
// Handshake bundle between the control unit and the multi-cycle MUL sequencer.
interface mul_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             start;
    logic             kill;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [RD_W-1:0]  rd_in;
    logic             stall;
    logic             busy;
    logic             done;
    logic             regwrite;
    logic [RD_W-1:0]  rd_out;
    logic [WIDTH-1:0] result;

    modport master (
        output start, kill, op_a, op_b, rd_in,
        input  stall, busy, done, regwrite, rd_out, result
    );

    modport slave (
        input  start, kill, op_a, op_b, rd_in,
        output stall, busy, done, regwrite, rd_out, result
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add sequencer for RV32M MUL: WIDTH iterations, one writeback pulse.
//   state | meaning
//   IDLE  | no op in flight, waiting for start
//   RUN   | shift-add iterations, cnt counts 0..WIDTH-1
//   DONE  | one-cycle writeback of result/rd_out; may accept the next op
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input logic  clk,
    input logic  rst,
    mul_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mcand, mplr, acc, acc_next, result_q;
    logic [RD_W-1:0]  rd_q, rd_out_q;
    logic [CNT_W-1:0] cnt;
    logic             accept, last;

    assign accept   = bus.start & ((state == IDLE) | (state == DONE)) & ~bus.kill;
    assign last     = (state == RUN) & (cnt == CNT_W'(WIDTH - 1));
    assign acc_next = mplr[0] ? acc + mcand : acc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
                if (bus.kill)  state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplr     <= '0;
            acc      <= '0;
            cnt      <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mcand <= bus.op_a;
                mplr  <= bus.op_b;
                rd_q  <= bus.rd_in;
                acc   <= '0;
                cnt   <= '0;
            end else if ((state == RUN) && !bus.kill) begin
                acc   <= acc_next;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + CNT_W'(1);
                // Capture on the final iteration so DONE presents a stable value.
                if (last) begin
                    result_q <= acc_next;
                    rd_out_q <= rd_q;
                end
            end
        end
    end

    assign bus.stall    = accept | (state == RUN);
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.regwrite = (state == DONE);
    assign bus.rd_out   = rd_out_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: directed corner cases plus random operands vs a*b.
module tb_mul_sequencer;
    localparam int WIDTH = 32;
    localparam int RD_W  = 5;
    localparam int LAT   = WIDTH + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [RD_W-1:0]  rd;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [WIDTH-1:0] last_res = '0;
    logic prev_done = 1'b0;

    mul_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus();

    mul_sequencer #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one op at the current negedge; the expected response is a*b truncated.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [RD_W-1:0] r, input bit push);
        exp_t e;
        logic [WIDTH-1:0] prod;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.rd_in = r;
        #1;
        check("stall_on_start", {31'b0, bus.stall}, 32'd1);
        check("busy_on_start", {31'b0, bus.busy}, 32'd0);
        prod  = a * b;
        e.res = prod;
        e.rd  = r;
        e.cyc = cyc + LAT;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: pending %0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            check("done_width", {31'b0, prev_done}, 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("rd_out", {{(WIDTH-RD_W){1'b0}}, bus.rd_out}, {{(WIDTH-RD_W){1'b0}}, e.rd});
                check("regwrite", {31'b0, bus.regwrite}, 32'd1);
                check("latency", cyc, e.cyc);
                last_res = e.res;
            end
        end
        prev_done = bus.done;
    end

    initial begin
        int n;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.rd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd_out", {27'b0, bus.rd_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'd3, 32'd5, 5'd7, 1'b1);
        check("busy_in_run", {31'b0, bus.busy}, 32'd1);
        wait_empty();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1);
        wait_empty();
        issue(32'h0001_0000, 32'h0001_0000, 5'd2, 1'b1);
        wait_empty();
        issue(32'h1234_5678, 32'd0, 5'd3, 1'b1);
        wait_empty();

        // start during RUN must be ignored
        issue(32'd11, 32'd13, 5'd4, 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.rd_in = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();
        repeat (5) @(negedge clk);

        // kill in RUN: no writeback, result holds
        issue(32'd100, 32'd200, 5'd10, 1'b0);
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_stall", {31'b0, bus.stall}, 32'd0);
        check("kill_busy", {31'b0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("kill_result_hold", bus.result, last_res);

        // reset in RUN clears everything
        issue(32'd7, 32'd7, 5'd11, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", {31'b0, bus.stall}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_rd_out", {27'b0, bus.rd_out}, 32'd0);
        rst = 1'b0;
        last_res = '0;
        repeat (40) @(negedge clk);

        // back-to-back: second op accepted in the DONE cycle
        issue(32'd6, 32'd7, 5'd12, 1'b1);
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done_seen", {31'b0, bus.done}, 32'd1);
        issue(32'd2, 32'd4, 5'd13, 1'b1);
        wait_empty();

        for (int i = 0; i < 20; i++) begin
            issue($urandom, $urandom, RD_W'($urandom_range(0, 31)), 1'b1);
            wait_empty();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
